// File: rtl/trigger_encoder_gen.sv
// trigger_encoder_gen: registered trigger-bit encoder. Passes per-BX trigger
// hits through and substitutes a synchronisation word on the empty BCID slot.
// Optional build macro TRIG_COLLISION_CNT_EN adds detection and saturating
// counting of trigger hits dropped by sync insertion; without it errFlag and
// errCount are tied to zero and clearErr is ignored.
module trigger_encoder_gen #(
   parameter int TRIG_WIDTH   = 16,
   parameter int BCID_WIDTH   = 12,
   parameter int ERRCNT_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [1:0]              syncMode,
   input  logic [TRIG_WIDTH-1:0]   trigHits,
   input  logic [BCID_WIDTH-1:0]   BCID,
   input  logic [BCID_WIDTH-1:0]   emptySlotBCID,
   input  logic                    clearErr,
   output logic [TRIG_WIDTH-1:0]   encTrigHits,
   output logic                    syncValid,
   output logic                    errFlag,
   output logic [ERRCNT_WIDTH-1:0] errCount
);

   localparam int PTR_W = (TRIG_WIDTH > 1) ? $clog2(TRIG_WIDTH) : 1;
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(TRIG_WIDTH - 1);

   logic [1:0]            mode_q, mode_d;
   logic [TRIG_WIDTH-1:0] slot_cnt_q, slot_cnt_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [TRIG_WIDTH-1:0] enc_q, enc_d;
   logic                  sync_valid_q, sync_valid_d;

   logic                  mode_change;
   logic                  empty_slot;
   logic [TRIG_WIDTH-1:0] slot_cnt_eff;
   logic [PTR_W-1:0]      ptr_eff;
   logic [TRIG_WIDTH-1:0] sync_word;

   // A mode switch restarts the sequence: the counters read as zero this cycle.
   assign mode_change  = (syncMode != mode_q);
   assign slot_cnt_eff = mode_change ? '0 : slot_cnt_q;
   assign ptr_eff      = mode_change ? '0 : ptr_q;
   assign empty_slot   = (BCID == emptySlotBCID) && enable && (syncMode != 2'd3);

   // Sync word selection for the current mode from the effective counters.
   always_comb begin
      sync_word = '0;
      case (syncMode)
         2'd0:    sync_word = {TRIG_WIDTH{~slot_cnt_eff[0]}};
         2'd1:    sync_word[ptr_eff] = 1'b1;
         2'd2:    sync_word = slot_cnt_eff;
         default: sync_word = '0;
      endcase
   end

   // Next-state for the encoded word and the per-mode sync counters.
   always_comb begin
      mode_d       = mode_q;
      slot_cnt_d   = slot_cnt_q;
      ptr_d        = ptr_q;
      enc_d        = '0;
      sync_valid_d = 1'b0;
      if (enable) begin
         mode_d     = syncMode;
         slot_cnt_d = slot_cnt_eff;
         ptr_d      = ptr_eff;
         if (empty_slot) begin
            enc_d        = sync_word;
            sync_valid_d = 1'b1;
            if (syncMode == 2'd1)
               ptr_d = (ptr_eff == PTR_MAX) ? '0 : ptr_eff + PTR_W'(1);
            else
               slot_cnt_d = slot_cnt_eff + TRIG_WIDTH'(1);
         end else begin
            enc_d = trigHits;
         end
      end
   end

   // State and output registers; reset clears outputs without waiting for clk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q       <= '0;
         slot_cnt_q   <= '0;
         ptr_q        <= '0;
         enc_q        <= '0;
         sync_valid_q <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         slot_cnt_q   <= slot_cnt_d;
         ptr_q        <= ptr_d;
         enc_q        <= enc_d;
         sync_valid_q <= sync_valid_d;
      end
   end

   assign encTrigHits = enc_q;
   assign syncValid   = sync_valid_q;

`ifdef TRIG_COLLISION_CNT_EN
   logic                    collision;
   logic                    err_flag_q, err_flag_d;
   logic [ERRCNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   // Hits arriving on an empty slot are overwritten by the sync word.
   assign collision = empty_slot && (trigHits != '0);

   // Error pulse and saturating counter; a clear wins over a same-cycle collision.
   always_comb begin
      err_flag_d = collision;
      err_cnt_d  = err_cnt_q;
      if (clearErr)
         err_cnt_d = '0;
      else if (collision && (err_cnt_q != {ERRCNT_WIDTH{1'b1}}))
         err_cnt_d = err_cnt_q + ERRCNT_WIDTH'(1);
   end

   // Collision state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_flag_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         err_flag_q <= err_flag_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign errFlag  = err_flag_q;
   assign errCount = err_cnt_q;
`else
   logic unused_clear_err;
   assign unused_clear_err = clearErr;
   assign errFlag          = 1'b0;
   assign errCount         = '0;
`endif

endmodule

// File: tb/tb_trigger_encoder_gen.sv
// Bench for trigger_encoder_gen: three instances (widths 16, 5, 4) share one
// stimulus stream and are checked against a slot-count reference model.
module tb_trigger_encoder_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, enable, clearErr;
   logic [1:0]  syncMode;
   logic [63:0] hits;
   logic [11:0] bcid, slot;

   logic [15:0] enc16;
   logic [4:0]  enc5;
   logic [3:0]  enc4;
   logic        sv16, sv5, sv4, ef16, ef5, ef4;
   logic [1:0]  ec16, ec5, ec4;

   trigger_encoder_gen #(.TRIG_WIDTH(16), .BCID_WIDTH(12), .ERRCNT_WIDTH(2)) u16 (
      .clk(clk), .reset(reset), .enable(enable), .syncMode(syncMode),
      .trigHits(hits[15:0]), .BCID(bcid), .emptySlotBCID(slot), .clearErr(clearErr),
      .encTrigHits(enc16), .syncValid(sv16), .errFlag(ef16), .errCount(ec16));
   trigger_encoder_gen #(.TRIG_WIDTH(5), .BCID_WIDTH(12), .ERRCNT_WIDTH(2)) u5 (
      .clk(clk), .reset(reset), .enable(enable), .syncMode(syncMode),
      .trigHits(hits[4:0]), .BCID(bcid), .emptySlotBCID(slot), .clearErr(clearErr),
      .encTrigHits(enc5), .syncValid(sv5), .errFlag(ef5), .errCount(ec5));
   trigger_encoder_gen #(.TRIG_WIDTH(4), .BCID_WIDTH(12), .ERRCNT_WIDTH(2)) u4 (
      .clk(clk), .reset(reset), .enable(enable), .syncMode(syncMode),
      .trigHits(hits[3:0]), .BCID(bcid), .emptySlotBCID(slot), .clearErr(clearErr),
      .encTrigHits(enc4), .syncValid(sv4), .errFlag(ef4), .errCount(ec4));

   int total = 0;
   int bad   = 0;

   // Reference model: k = empty slots seen since the last mode change / reset.
   longint unsigned k;
   logic [1:0]      mreg;
   int              ecnt    [3];
   logic [63:0]     exp_enc [3];
   logic            exp_sv  [3];
   logic            exp_ef  [3];
   logic [1:0]      exp_ec  [3];

   function automatic int wid(input int i);
      return (i == 0) ? 16 : (i == 1) ? 5 : 4;
   endfunction

   function automatic logic [63:0] wmask(input int i);
      return (64'd1 << wid(i)) - 64'd1;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      k    = 0;
      mreg = 2'd0;
      for (int i = 0; i < 3; i++) begin
         ecnt[i] = 0; exp_enc[i] = '0; exp_sv[i] = 0; exp_ef[i] = 0; exp_ec[i] = '0;
      end
   endtask

   // Advance the model on one clock edge using the inputs present at that edge.
   task automatic model_step();
      bit empty;
      for (int i = 0; i < 3; i++) begin
         exp_enc[i] = '0; exp_sv[i] = 0; exp_ef[i] = 0;
      end
      if (enable) begin
         if (syncMode != mreg) k = 0;
         mreg  = syncMode;
         empty = (bcid == slot) && (syncMode != 2'd3);
         for (int i = 0; i < 3; i++) begin
            logic [63:0] h;
            h = hits & wmask(i);
            if (empty) begin
               exp_sv[i] = 1;
               case (syncMode)
                  2'd0:    exp_enc[i] = (k % 2 == 0) ? wmask(i) : 64'd0;
                  2'd1:    exp_enc[i] = 64'd1 << (k % longint'(wid(i)));
                  default: exp_enc[i] = k % (64'd1 << wid(i));
               endcase
            end else begin
               exp_enc[i] = h;
            end
`ifdef TRIG_COLLISION_CNT_EN
            exp_ef[i] = empty && (h != 0);
            if (clearErr)       ecnt[i] = 0;
            else if (exp_ef[i]) ecnt[i] = (ecnt[i] < 3) ? ecnt[i] + 1 : 3;
            exp_ec[i] = 2'(ecnt[i]);
`endif
         end
         if (empty) k++;
      end
`ifdef TRIG_COLLISION_CNT_EN
      else if (clearErr) begin
         for (int i = 0; i < 3; i++) begin ecnt[i] = 0; exp_ec[i] = '0; end
      end
`endif
   endtask

   task automatic compare_all(input string tag);
      check({tag, " enc16"}, {48'd0, enc16}, exp_enc[0]);
      check({tag, " enc5"},  {59'd0, enc5},  exp_enc[1]);
      check({tag, " enc4"},  {60'd0, enc4},  exp_enc[2]);
      check({tag, " sv16"}, {63'd0, sv16}, {63'd0, exp_sv[0]});
      check({tag, " sv5"},  {63'd0, sv5},  {63'd0, exp_sv[1]});
      check({tag, " sv4"},  {63'd0, sv4},  {63'd0, exp_sv[2]});
      check({tag, " ef16"}, {63'd0, ef16}, {63'd0, exp_ef[0]});
      check({tag, " ef5"},  {63'd0, ef5},  {63'd0, exp_ef[1]});
      check({tag, " ef4"},  {63'd0, ef4},  {63'd0, exp_ef[2]});
      check({tag, " ec16"}, {62'd0, ec16}, {62'd0, exp_ec[0]});
      check({tag, " ec5"},  {62'd0, ec5},  {62'd0, exp_ec[1]});
      check({tag, " ec4"},  {62'd0, ec4},  {62'd0, exp_ec[2]});
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_step();
      #1;
      compare_all(tag);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      compare_all("reset");
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   typedef struct {
      logic        en;
      logic [1:0]  mode;
      logic [11:0] bcid;
      logic [15:0] hits;
      logic [15:0] exp_enc;
      logic        exp_sv;
   } vec_t;
   vec_t tbl [11];

   logic [15:0] sweep_sync [$];
   logic [4:0]  walk5 [7];

   initial begin
      tbl[0]  = '{1'b1, 2'd0, 12'h001, 16'h1234, 16'h1234, 1'b0};
      tbl[1]  = '{1'b1, 2'd0, 12'h0A5, 16'h0000, 16'hFFFF, 1'b1};
      tbl[2]  = '{1'b1, 2'd0, 12'h0A6, 16'h1234, 16'h1234, 1'b0};
      tbl[3]  = '{1'b1, 2'd0, 12'h0A5, 16'h0000, 16'h0000, 1'b1};
      tbl[4]  = '{1'b1, 2'd1, 12'h0A5, 16'h0000, 16'h0001, 1'b1};
      tbl[5]  = '{1'b1, 2'd1, 12'h0A5, 16'h0000, 16'h0002, 1'b1};
      tbl[6]  = '{1'b1, 2'd3, 12'h0A5, 16'hBEEF, 16'hBEEF, 1'b0};
      tbl[7]  = '{1'b1, 2'd2, 12'h0A5, 16'h0000, 16'h0000, 1'b1};
      tbl[8]  = '{1'b1, 2'd2, 12'h0A5, 16'h0000, 16'h0001, 1'b1};
      tbl[9]  = '{1'b0, 2'd2, 12'h100, 16'hFFFF, 16'h0000, 1'b0};
      tbl[10] = '{1'b1, 2'd2, 12'h0A5, 16'h0000, 16'h0002, 1'b1};
      walk5   = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01, 5'h02};

      reset = 1'b0; enable = 1'b1; clearErr = 1'b0; syncMode = 2'd0;
      hits = '0; bcid = '0; slot = 12'h0A5;
      model_reset();
      #2;
      compare_all("power-on reset");
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;

      // Table-driven vectors on the 16-bit instance (model also checks all widths)
      for (int v = 0; v < 11; v++) begin
         enable = tbl[v].en; syncMode = tbl[v].mode; bcid = tbl[v].bcid;
         hits = {48'd0, tbl[v].hits};
         step($sformatf("vec%0d", v));
         check($sformatf("vec%0d tbl enc", v), {48'd0, enc16}, {48'd0, tbl[v].exp_enc});
         check($sformatf("vec%0d tbl sv", v), {63'd0, sv16}, {63'd0, tbl[v].exp_sv});
         $display("vec%0d en=%0d mode=%0d bcid=%03h hits=%04h -> enc=%04h sv=%0d",
                  v, tbl[v].en, tbl[v].mode, tbl[v].bcid, tbl[v].hits, enc16, sv16);
      end

      // Mode 0 sweep over the full BCID range twice
      do_reset();
      syncMode = 2'd0; hits = 64'h1234; enable = 1'b1;
      for (int p = 0; p < 2; p++) begin
         for (int b = 0; b < 4096; b++) begin
            bcid = 12'(b);
            step("sweep");
            if (sv16) sweep_sync.push_back(enc16);
         end
      end
      check("sweep sync count", 64'(sweep_sync.size()), 64'd2);
      if (sweep_sync.size() == 2) begin
         check("sweep sync0", {48'd0, sweep_sync[0]}, 64'hFFFF);
         check("sweep sync1", {48'd0, sweep_sync[1]}, 64'h0000);
      end
      $display("sweep done: %0d sync words", sweep_sync.size());

      // Walking one, width 5, seven consecutive empty slots
      do_reset();
      syncMode = 2'd1; bcid = slot; hits = '0;
      for (int i = 0; i < 7; i++) begin
         step("walk");
         check($sformatf("walk5[%0d]", i), {59'd0, enc5}, {59'd0, walk5[i]});
         $display("walk slot %0d: enc5=%02h", i, enc5);
      end

      // Slot counter, width 4, 18 empty slots with wrap
      syncMode = 2'd2;
      for (int i = 0; i < 18; i++) begin
         step("cnt");
         check($sformatf("cnt4[%0d]", i), {60'd0, enc4}, 64'(i % 16));
         $display("count slot %0d: enc4=%0h", i, enc4);
      end

      // Collisions: five dropped hits, then clear together with a collision
      do_reset();
      syncMode = 2'd0; bcid = slot; hits = 64'h1;
      for (int i = 0; i < 5; i++) begin
         step("coll");
`ifdef TRIG_COLLISION_CNT_EN
         check($sformatf("coll%0d ef", i), {63'd0, ef16}, 64'd1);
         check($sformatf("coll%0d ec", i), {62'd0, ec16}, (i < 3) ? 64'(i + 1) : 64'd3);
`else
         check($sformatf("coll%0d ef", i), {63'd0, ef16}, 64'd0);
         check($sformatf("coll%0d ec", i), {62'd0, ec16}, 64'd0);
`endif
         $display("collision %0d: errFlag=%0d errCount=%0d", i, ef16, ec16);
      end
      clearErr = 1'b1;
      step("clear");
      check("clear ec", {62'd0, ec16}, 64'd0);
      $display("clear+collision: errFlag=%0d errCount=%0d", ef16, ec16);
      clearErr = 1'b0; hits = '0; bcid = 12'h000;
      step("coll idle");

      // Disabled slots hold the sequence; then an asynchronous reset mid-cycle
      do_reset();
      syncMode = 2'd0; bcid = slot; hits = '0;
      step("en first");
      check("en first", {48'd0, enc16}, 64'hFFFF);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step("disabled");
         check($sformatf("disabled%0d enc", i), {48'd0, enc16}, 64'd0);
         $display("disabled slot %0d: enc=%04h", i, enc16);
      end
      enable = 1'b1;
      step("re-enable");
      check("re-enable enc", {48'd0, enc16}, 64'h0000);
      check("re-enable sv", {63'd0, sv16}, 64'd1);
      bcid = 12'h001; hits = 64'hABCD;
      step("pre-reset");
      #3;
      reset = 1'b0;
      #1;
      model_reset();
      compare_all("async reset");
      $display("async reset mid-cycle: enc=%04h sv=%0d", enc16, sv16);
      @(posedge clk); #1;
      reset = 1'b1;

      // Randomised traffic against the model
      for (int n = 0; n < 3000; n++) begin
         enable   = ($urandom % 10) != 0;
         if (($urandom % 50) == 0) syncMode = 2'($urandom % 4);
         bcid     = slot + 12'($urandom % 3);
         hits     = (($urandom % 3) == 0) ? {$urandom, $urandom} : 64'd0;
         clearErr = enable && (($urandom % 40) == 0);
         step("rand");
      end
      clearErr = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
